// File: rtl/commit_checker.sv
// Lockstep commit checker: buffers retired-instruction records from the core and
// compares each against a golden record stream, flagging the first divergence.
module commit_checker #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cm_valid_i,
  input  logic [XLEN-1:0]   cm_pc_i,
  input  logic [31:0]       cm_ir_i,
  input  logic              cm_rf_we_i,
  input  logic [4:0]        cm_rd_i,
  input  logic [XLEN-1:0]   cm_rf_wdata_i,
  input  logic              cm_mem_we_i,
  input  logic [XLEN-1:0]   cm_mem_addr_i,
  input  logic [XLEN-1:0]   cm_mem_wdata_i,
  input  logic [XLEN/8-1:0] cm_mem_wstrb_i,
  input  logic              ref_valid_i,
  output logic              ref_ready_o,
  input  logic [XLEN-1:0]   ref_pc_i,
  input  logic [31:0]       ref_ir_i,
  input  logic              ref_rf_we_i,
  input  logic [4:0]        ref_rd_i,
  input  logic [XLEN-1:0]   ref_rf_wdata_i,
  input  logic              ref_mem_we_i,
  input  logic [XLEN-1:0]   ref_mem_addr_i,
  input  logic [XLEN-1:0]   ref_mem_wdata_i,
  input  logic [XLEN/8-1:0] ref_mem_wstrb_i,
  output logic [63:0]       checked_cnt_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [2:0]        err_code_o,
  output logic [XLEN-1:0]   fail_pc_o
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] UNIMP = 32'hc0001073;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_PC   = 3'd1;
  localparam logic [2:0] ERR_IR   = 3'd2;
  localparam logic [2:0] ERR_RF   = 3'd3;
  localparam logic [2:0] ERR_MEM  = 3'd4;
  localparam logic [2:0] ERR_OVF  = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic            rf_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rf_wdata;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [SW-1:0]   mem_wstrb;
  } rec_t;

  typedef enum logic [1:0] {S_RUN, S_FAIL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]     checked_cnt_q, checked_cnt_d;
  logic            done_q, done_d, fail_q, fail_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [XLEN-1:0] fail_pc_q, fail_pc_d;
  rec_t            mem_q [DEPTH];

  rec_t            cm_rec, ref_rec, head;
  logic            empty, full, pop, push;
  logic [2:0]      cmp_code;
  logic [XLEN-1:0] byte_mask;
  logic            cm_rf_eff, ref_rf_eff, rf_bad, mem_bad;

  assign cm_rec  = '{pc: cm_pc_i, ir: cm_ir_i, rf_we: cm_rf_we_i, rd: cm_rd_i,
                     rf_wdata: cm_rf_wdata_i, mem_we: cm_mem_we_i, mem_addr: cm_mem_addr_i,
                     mem_wdata: cm_mem_wdata_i, mem_wstrb: cm_mem_wstrb_i};
  assign ref_rec = '{pc: ref_pc_i, ir: ref_ir_i, rf_we: ref_rf_we_i, rd: ref_rd_i,
                     rf_wdata: ref_rf_wdata_i, mem_we: ref_mem_we_i, mem_addr: ref_mem_addr_i,
                     mem_wdata: ref_mem_wdata_i, mem_wstrb: ref_mem_wstrb_i};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign ref_ready_o = (state_q == S_RUN) && !empty;
  assign pop         = ref_valid_i && ref_ready_o;
  assign push        = cm_valid_i && (!full || pop);

  // Field comparison at the FIFO head, highest-priority mismatch wins.
  always_comb begin
    cmp_code  = ERR_NONE;
    byte_mask = '0;
    for (int i = 0; i < int'(SW); i++) begin
      byte_mask[i*8 +: 8] = {8{head.mem_wstrb[i]}};
    end
    cm_rf_eff  = head.rf_we && (head.rd != 5'd0);
    ref_rf_eff = ref_rec.rf_we && (ref_rec.rd != 5'd0);
    rf_bad     = (cm_rf_eff != ref_rf_eff) ||
                 (cm_rf_eff && ((head.rd != ref_rec.rd) || (head.rf_wdata != ref_rec.rf_wdata)));
    mem_bad    = (head.mem_we != ref_rec.mem_we) ||
                 (head.mem_we && ((head.mem_addr != ref_rec.mem_addr) ||
                                  (head.mem_wstrb != ref_rec.mem_wstrb) ||
                                  ((head.mem_wdata & byte_mask) != (ref_rec.mem_wdata & byte_mask))));
    if (head.pc != ref_rec.pc)      cmp_code = ERR_PC;
    else if (head.ir != ref_rec.ir) cmp_code = ERR_IR;
    else if (rf_bad)                cmp_code = ERR_RF;
    else if (mem_bad)               cmp_code = ERR_MEM;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    checked_cnt_d = checked_cnt_q;
    done_d        = done_q;
    fail_d        = fail_q;
    err_code_d    = err_code_q;
    fail_pc_d     = fail_pc_q;
    if (pop) begin
      if (cmp_code == ERR_NONE) begin
        checked_cnt_d = checked_cnt_q + 64'd1;
        if (head.ir == UNIMP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end else begin
        state_d    = S_FAIL;
        fail_d     = 1'b1;
        err_code_d = cmp_code;
        fail_pc_d  = head.pc;
      end
    end else if (cm_valid_i && full && (state_q == S_RUN)) begin
      state_d    = S_FAIL;
      fail_d     = 1'b1;
      err_code_d = ERR_OVF;
      fail_pc_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      checked_cnt_q <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_code_q    <= ERR_NONE;
      fail_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      checked_cnt_q <= checked_cnt_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      err_code_q    <= err_code_d;
      fail_pc_q     <= fail_pc_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cm_rec;
  end

  assign checked_cnt_o = checked_cnt_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign err_code_o    = err_code_q;
  assign fail_pc_o     = fail_pc_q;

endmodule
